// File: rtl/cpu_run_ctrl_pkg.sv
// cpu_run_ctrl shared types and constants.
// Run states, default parameters, elaboration helpers.
package cpu_run_pkg;

  typedef enum logic [1:0] {
    S_HOLD,
    S_RELEASE,
    S_RUN,
    S_DONE
  } state_t;

  localparam int DEF_N_CPU      = 1;
  localparam int DEF_RST_CYCLES = 10;
  localparam int DEF_STAGGER    = 0;
  localparam int DEF_MAX_CYCLES = 500;
  localparam int DEF_CNT_W      = 32;

  function automatic int cnt_w(input int v);
    return (v < 2) ? 1 : $clog2(v + 1);
  endfunction

  function automatic bit cfg_ok(
    input int n,
    input int r,
    input int s
  );
    return (n >= 1) && (n <= 16) &&
           (r >= 1) && (s >= 0);
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Run-control bundle between controller and
// the cores / bench.
interface cpu_run_ctrl_if #(
  parameter int N_CPU = 1,
  parameter int CNT_W = 32
);
  logic             hold;
  logic [N_CPU-1:0] halt_req;
  logic [N_CPU-1:0] cpu_rst;
  logic             running;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    input  hold,
    input  halt_req,
    output cpu_rst,
    output running,
    output done,
    output timeout,
    output cycle_count
  );

  modport slave (
    output hold,
    output halt_req,
    input  cpu_rst,
    input  running,
    input  done,
    input  timeout,
    input  cycle_count
  );
endinterface

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Up-counter with synchronous clear and
// saturation at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (en && !(&q))
      q <= q + W'(1);
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: reset stretch, staggered core
// release, cycle budget and all-halt detection.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int N_CPU      = DEF_N_CPU,
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int STAGGER    = DEF_STAGGER,
  parameter int MAX_CYCLES = DEF_MAX_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  cpu_run_ctrl_if.master bus
);

  localparam int HW = cnt_w(RST_CYCLES);
  localparam int SW = cnt_w(STAGGER);
  localparam int IW =
    (N_CPU > 1) ? $clog2(N_CPU) : 1;
  localparam bit STAG =
    (N_CPU > 1) && (STAGGER > 0);

  if (!cfg_ok(N_CPU, RST_CYCLES, STAGGER)) begin : g_bad
    $error("cpu_run_ctrl: bad parameters");
  end

  state_t           state;
  logic [N_CPU-1:0] cpu_rst;
  logic [N_CPU-1:0] halted;
  logic [N_CPU-1:0] hv;
  logic [IW-1:0]    idx;
  logic [HW-1:0]    hcnt;
  logic [SW-1:0]    scnt;
  logic [CNT_W-1:0] ccnt;
  logic             running;
  logic             done;
  logic             timeout;
  logic             act;
  logic             hit0;
  logic             sc_hit;
  logic             all_h;
  logic             bud;

  always_comb begin
    act    = (state == S_RELEASE) ||
             (state == S_RUN);
    hit0   = (hcnt == HW'(RST_CYCLES - 1));
    sc_hit = (scnt == SW'(STAGGER - 1));
    hv     = halted | (bus.halt_req & ~cpu_rst);
    all_h  = (state == S_RUN) && (&hv);
    // budget hit = the increment about to land on MAX_CYCLES
    bud    = (MAX_CYCLES != 0) && !(&ccnt) &&
             (64'(ccnt) + 64'd1 == 64'(MAX_CYCLES));
  end

  sat_counter #(.W(HW)) u_hold (
    .clk (clk),
    .rst (rst),
    .clr (bus.hold || (state != S_HOLD)),
    .en  (1'b1),
    .q   (hcnt)
  );

  sat_counter #(.W(SW)) u_stag (
    .clk (clk),
    .rst (rst),
    .clr (bus.hold || (state != S_RELEASE) ||
          sc_hit),
    .en  (1'b1),
    .q   (scnt)
  );

  sat_counter #(.W(CNT_W)) u_cyc (
    .clk (clk),
    .rst (rst),
    .clr (bus.hold || (state == S_HOLD)),
    .en  (act && !all_h),
    .q   (ccnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_HOLD;
      cpu_rst <= '1;
      halted  <= '0;
      idx     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
    end else if (bus.hold) begin
      state   <= S_HOLD;
      cpu_rst <= '1;
      halted  <= '0;
      idx     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      unique case (state)
        S_HOLD: begin
          if (hit0) begin
            running <= 1'b1;
            idx     <= IW'(1);
            if (STAG) begin
              state      <= S_RELEASE;
              cpu_rst[0] <= 1'b0;
            end else begin
              state   <= S_RUN;
              cpu_rst <= '0;
            end
          end
        end
        S_RELEASE: begin
          halted <= hv;
          if (bud) begin
            state   <= S_DONE;
            running <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else if (sc_hit) begin
            cpu_rst <= cpu_rst &
                       ~(N_CPU'(1) << idx);
            idx     <= idx + IW'(1);
            if (idx == IW'(N_CPU - 1))
              state <= S_RUN;
          end
        end
        S_RUN: begin
          halted <= hv;
          if (all_h) begin
            state   <= S_DONE;
            running <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b0;
          end else if (bud) begin
            state   <= S_DONE;
            running <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end
        end
        S_DONE: begin
        end
      endcase
    end
  end

  assign bus.cpu_rst     = cpu_rst;
  assign bus.running     = running;
  assign bus.done        = done;
  assign bus.timeout     = timeout;
  assign bus.cycle_count = ccnt;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: four configurations
// checked against an edge-count model.
module tb_cpu_run_ctrl;

  localparam int RC = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   chk_en = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl_if #(.N_CPU(1), .CNT_W(32)) if_a ();
  cpu_run_ctrl_if #(.N_CPU(3), .CNT_W(32)) if_b ();
  cpu_run_ctrl_if #(.N_CPU(2), .CNT_W(32)) if_c ();
  cpu_run_ctrl_if #(.N_CPU(1), .CNT_W(8))  if_d ();

  cpu_run_ctrl u_a (
    .clk (clk), .rst (rst), .bus (if_a)
  );
  cpu_run_ctrl #(
    .N_CPU (3), .STAGGER (4)
  ) u_b (
    .clk (clk), .rst (rst), .bus (if_b)
  );
  cpu_run_ctrl #(
    .N_CPU (2), .MAX_CYCLES (3)
  ) u_c (
    .clk (clk), .rst (rst), .bus (if_c)
  );
  cpu_run_ctrl #(
    .MAX_CYCLES (0), .CNT_W (8)
  ) u_d (
    .clk (clk), .rst (rst), .bus (if_d)
  );

  logic        hold_v [4];
  logic [15:0] halt_v [4];
  logic [15:0] o_rst  [4];
  logic        o_run  [4];
  logic        o_done [4];
  logic        o_to   [4];
  logic [63:0] o_cnt  [4];

  assign if_a.hold     = hold_v[0];
  assign if_b.hold     = hold_v[1];
  assign if_c.hold     = hold_v[2];
  assign if_d.hold     = hold_v[3];
  assign if_a.halt_req = halt_v[0][0:0];
  assign if_b.halt_req = halt_v[1][2:0];
  assign if_c.halt_req = halt_v[2][1:0];
  assign if_d.halt_req = halt_v[3][0:0];

  assign o_rst[0]  = 16'(if_a.cpu_rst);
  assign o_rst[1]  = 16'(if_b.cpu_rst);
  assign o_rst[2]  = 16'(if_c.cpu_rst);
  assign o_rst[3]  = 16'(if_d.cpu_rst);
  assign o_run[0]  = if_a.running;
  assign o_run[1]  = if_b.running;
  assign o_run[2]  = if_c.running;
  assign o_run[3]  = if_d.running;
  assign o_done[0] = if_a.done;
  assign o_done[1] = if_b.done;
  assign o_done[2] = if_c.done;
  assign o_done[3] = if_d.done;
  assign o_to[0]   = if_a.timeout;
  assign o_to[1]   = if_b.timeout;
  assign o_to[2]   = if_c.timeout;
  assign o_to[3]   = if_d.timeout;
  assign o_cnt[0]  = 64'(if_a.cycle_count);
  assign o_cnt[1]  = 64'(if_b.cycle_count);
  assign o_cnt[2]  = 64'(if_c.cycle_count);
  assign o_cnt[3]  = 64'(if_d.cycle_count);

  function automatic int nc(input int k);
    case (k)
      1:       return 3;
      2:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int stg(input int k);
    return (k == 1) ? 4 : 0;
  endfunction

  function automatic int mx(input int k);
    case (k)
      2:       return 3;
      3:       return 0;
      default: return 500;
    endcase
  endfunction

  function automatic logic [63:0] cmax(input int k);
    return (k == 3) ? 64'd255 : 64'hFFFF_FFFF;
  endfunction

  function automatic logic [15:0] msk(input int k);
    return 16'((32'd1 << nc(k)) - 32'd1);
  endfunction

  // e = edges since rst/hold release; core i is free
  // from edge RC + i*stagger until frozen by done
  typedef struct packed {
    logic [31:0] e;
    logic        st;
    logic        dn;
    logic        to;
    logic [15:0] rel;
    logic [15:0] hal;
    logic [63:0] cnt;
  } mdl_t;

  mdl_t m [4];

  function automatic mdl_t step(
    input mdl_t        s,
    input int          k,
    input logic        hold,
    input logic [15:0] hr
  );
    mdl_t        r;
    logic [63:0] nx;
    r = s;
    if (hold) return '0;
    if (s.dn) return r;
    r.e = s.e + 1;
    if (s.st) begin
      r.hal = s.hal | (hr & s.rel);
      nx = (s.cnt == cmax(k)) ? s.cnt
                              : s.cnt + 64'd1;
      if ((r.hal & msk(k)) == msk(k)) begin
        r.dn = 1'b1;
      end else if (mx(k) != 0 &&
                   nx == 64'(mx(k))) begin
        r.dn  = 1'b1;
        r.to  = 1'b1;
        r.cnt = nx;
      end else begin
        r.cnt = nx;
      end
    end else if (r.e == RC) begin
      r.st  = 1'b1;
      r.cnt = '0;
    end
    if (r.st && !r.dn)
      for (int i = 0; i < nc(k); i++)
        if (r.e == 32'(RC + i * stg(k)))
          r.rel[i] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++)
        m[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++)
        m[k] <= step(m[k], k, hold_v[k],
                     halt_v[k]);
    end
  end

  task automatic cmp(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 4; k++) begin
        cmp($sformatf("m%0d.cpu_rst", k),
            64'(o_rst[k]),
            64'(~m[k].rel & msk(k)));
        cmp($sformatf("m%0d.running", k),
            64'(o_run[k]),
            64'(m[k].st && !m[k].dn));
        cmp($sformatf("m%0d.done", k),
            64'(o_done[k]), 64'(m[k].dn));
        cmp($sformatf("m%0d.timeout", k),
            64'(o_to[k]), 64'(m[k].to));
        cmp($sformatf("m%0d.count", k),
            o_cnt[k], m[k].cnt & cmax(k));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      hold_v[k] = 1'b0;
      halt_v[k] = '0;
    end
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(9);
    cmp("a.rst_e9", o_rst[0], 16'h1);
    cmp("b.rst_e9", o_rst[1], 16'h7);
    tick(1);
    cmp("a.rst_e10", o_rst[0], 16'h0);
    cmp("a.run_e10", 64'(o_run[0]), 64'd1);
    cmp("a.cnt_e10", o_cnt[0], 64'd0);
    cmp("b.rst_e10", o_rst[1], 16'h6);
    tick(1);
    halt_v[1] = 16'h4;
    tick(1);
    halt_v[1] = 16'h0;
    halt_v[2] = 16'h3;
    tick(1);
    cmp("c.done", 64'(o_done[2]), 64'd1);
    cmp("c.tmo", 64'(o_to[2]), 64'd0);
    cmp("c.cnt", o_cnt[2], 64'd2);
    halt_v[2] = 16'h0;
    tick(1);
    cmp("b.rst_e14", o_rst[1], 16'h4);
    tick(4);
    cmp("b.rst_e18", o_rst[1], 16'h0);
    tick(2);
    cmp("b.done_e20", 64'(o_done[1]), 64'd0);
    halt_v[1] = 16'h7;
    tick(1);
    cmp("b.done", 64'(o_done[1]), 64'd1);
    cmp("b.tmo", 64'(o_to[1]), 64'd0);
    halt_v[1] = 16'h0;
    tick(26);
    cmp("a.cnt37", o_cnt[0], 64'd37);
    halt_v[0] = 16'h1;
    tick(1);
    cmp("a.hdone", 64'(o_done[0]), 64'd1);
    cmp("a.htmo", 64'(o_to[0]), 64'd0);
    cmp("a.hcnt", o_cnt[0], 64'd37);
    cmp("a.hrun", 64'(o_run[0]), 64'd0);
    halt_v[0] = 16'h0;
    hold_v[0] = 1'b1;
    tick(1);
    cmp("a.hold_rst", o_rst[0], 16'h1);
    cmp("a.hold_done", 64'(o_done[0]), 64'd0);
    hold_v[0] = 1'b0;
    tick(10);
    cmp("a.rerel", o_rst[0], 16'h0);
    tick(100);
    cmp("a.cnt100", o_cnt[0], 64'd100);
    hold_v[0] = 1'b1;
    tick(1);
    cmp("a.h2_rst", o_rst[0], 16'h1);
    cmp("a.h2_cnt", o_cnt[0], 64'd0);
    hold_v[0] = 1'b0;
    tick(9);
    cmp("a.h2_e9", o_rst[0], 16'h1);
    tick(1);
    cmp("a.h2_e10", o_rst[0], 16'h0);
    tick(499);
    cmp("a.pre_done", 64'(o_done[0]), 64'd0);
    cmp("a.cnt499", o_cnt[0], 64'd499);
    tick(1);
    cmp("a.bdone", 64'(o_done[0]), 64'd1);
    cmp("a.btmo", 64'(o_to[0]), 64'd1);
    cmp("a.bcnt", o_cnt[0], 64'd500);
    cmp("d.sat", o_cnt[3], 64'd255);
    cmp("d.done", 64'(o_done[3]), 64'd0);
    tick(5);
    cmp("a.frozen", o_cnt[0], 64'd500);
    cmp("d.sat2", o_cnt[3], 64'd255);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    cmp("d.ar_rst", o_rst[3], 16'h1);
    cmp("d.ar_run", 64'(o_run[3]), 64'd0);
    cmp("d.ar_cnt", o_cnt[3], 64'd0);
    cmp("a.ar_done", 64'(o_done[0]), 64'd0);
    cmp("a.ar_tmo", 64'(o_to[0]), 64'd0);
    tick(2);
    rst = 1'b0;
    tick(9);
    cmp("d.r_e9", o_rst[3], 16'h1);
    tick(1);
    cmp("d.r_e10", o_rst[3], 16'h0);
    cmp("d.r_run", 64'(o_run[3]), 64'd1);
    cmp("a.r_e10", o_rst[0], 16'h0);
    tick(3);
    cmp("c.r_tmo", 64'(o_to[2]), 64'd1);
    cmp("c.r_cnt", o_cnt[2], 64'd3);
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
